// File: rtl/dispatch_controller_pkg.sv
// dispatch_controller_pkg: shared dispatch types, tag constants and tag-width helper
package dispatch_controller_pkg;
    localparam int NO_TAG = 0;
    typedef enum logic [0:0] {RUN, RECOVER} dispatch_state_t;
    function automatic int tag_width(input int size);
        return $clog2(size) + 1;
    endfunction
endpackage

// File: rtl/free_slot_picker.sv
// free_slot_picker: reports whether any slot is free and the lowest-index free slot
module free_slot_picker #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] busy,
    output logic         any_free,
    output logic [W-1:0] idx
);
    assign any_free = ~&busy;
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) idx = busy[i] ? idx : W'(i);
    end
endmodule

// File: rtl/dispatch_controller.sv
// dispatch_controller: dispatch allocation gating, ROB tag assignment and ROB/LSQ pointer ownership
module dispatch_controller
    import dispatch_controller_pkg::*;
#(
    parameter int ROB_SIZE = 16,
    parameter int RS_SIZE  = 8,
    parameter int LSQ_SIZE = 8,
    localparam int RB = $clog2(ROB_SIZE),
    localparam int LB = $clog2(LSQ_SIZE),
    localparam int SB = $clog2(RS_SIZE),
    localparam int TW = tag_width(ROB_SIZE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dis_valid,
    input  logic               bypass_rs,
    input  logic               needs_lsq,
    input  logic               writes_rd,
    input  logic [RS_SIZE-1:0] rs_busy,
    input  logic               commit,
    input  logic               lsq_retire,
    input  logic               flush,
    output logic               dis_fire,
    output logic               dis_stall,
    output logic               rob_we,
    output logic [RB-1:0]      rob_idx,
    output logic [TW-1:0]      dis_tag,
    output logic               rs_we,
    output logic [SB-1:0]      rs_idx,
    output logic               lsq_we,
    output logic [LB-1:0]      lsq_idx,
    output logic               mt_we,
    output logic [RB-1:0]      rob_head,
    output logic [RB:0]        rob_count,
    output logic [LB:0]        lsq_count,
    output logic [31:0]        stall_cycles
);
    dispatch_state_t state;
    logic [RB-1:0] rob_tail;
    logic [LB-1:0] lsq_head, lsq_tail;
    logic rs_free, rob_ok, rs_ok, lsq_ok, rob_pop, lsq_pop;

    free_slot_picker #(.N(RS_SIZE)) u_rs_pick (.busy(rs_busy), .any_free(rs_free), .idx(rs_idx));

    // Resource checks see only registered occupancy; same-cycle frees help next cycle
    assign rob_ok    = rob_count < (RB+1)'(ROB_SIZE);
    assign rs_ok     = bypass_rs | rs_free;
    assign lsq_ok    = !needs_lsq | (lsq_count < (LB+1)'(LSQ_SIZE));
    assign dis_fire  = dis_valid & (state == RUN) & !flush & rob_ok & rs_ok & lsq_ok;
    assign dis_stall = dis_valid & !dis_fire;
    assign rob_we    = dis_fire;
    assign rs_we     = dis_fire & !bypass_rs;
    assign lsq_we    = dis_fire & needs_lsq;
    assign mt_we     = dis_fire & writes_rd;
    assign rob_idx   = rob_tail;
    assign lsq_idx   = lsq_tail;
    assign dis_tag   = TW'(rob_tail) + TW'(1);
    assign rob_pop   = commit & (rob_count != '0);
    assign lsq_pop   = lsq_retire & (lsq_count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            rob_head     <= '0;
            rob_tail     <= '0;
            rob_count    <= '0;
            lsq_head     <= '0;
            lsq_tail     <= '0;
            lsq_count    <= '0;
            stall_cycles <= '0;
        end else begin
            state        <= flush ? RECOVER : RUN;
            stall_cycles <= stall_cycles + 32'(dis_stall & ~&stall_cycles);
            if (flush) begin
                rob_head  <= '0;
                rob_tail  <= '0;
                rob_count <= '0;
                lsq_head  <= '0;
                lsq_tail  <= '0;
                lsq_count <= '0;
            end else begin
                rob_tail  <= rob_tail + RB'(rob_we);
                rob_head  <= rob_head + RB'(rob_pop);
                rob_count <= rob_count + (RB+1)'(rob_we) - (RB+1)'(rob_pop);
                lsq_tail  <= lsq_tail + LB'(lsq_we);
                lsq_head  <= lsq_head + LB'(lsq_pop);
                lsq_count <= lsq_count + (LB+1)'(lsq_we) - (LB+1)'(lsq_pop);
            end
        end
    end
endmodule

// File: doc/dispatch_controller.md
# dispatch_controller

Sequencing controller for the dispatch stage of the out-of-order core. Each cycle it decides whether the instruction held in the registers/dispatch pipeline register may allocate, issues write enables and slot indices for the ROB, reservation stations, LSQ and map table, and assigns the ROB tag. It owns the ROB and LSQ head/tail pointers and performs flush recovery. It sits beside the combinational allocator, which builds the entry contents.

## Interface
Parameters:
- ROB_SIZE, 16, ROB entries (power of two)
- RS_SIZE, 8, reservation-station entries
- LSQ_SIZE, 8, LSQ entries (power of two)

Ports (RB = $clog2(ROB_SIZE), LB = $clog2(LSQ_SIZE), SB = $clog2(RS_SIZE)):
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- dis_valid  in  1  dispatch register holds a valid instruction
- bypass_rs  in  1  allocator flag: instruction skips the RS (ecall, unsupported, JAL)
- needs_lsq  in  1  load or store (memtoreg | memwr)
- writes_rd  in  1  instruction renames rd (map-table write)
- rs_busy  in  RS_SIZE  busy bits of the RS array, registered state
- commit  in  1  ROB head retires this cycle
- lsq_retire  in  1  LSQ head frees this cycle
- flush  in  1  mispredict/exception flush
- dis_fire  out  1  dispatch accepted this cycle
- dis_stall  out  1  dis_valid & !dis_fire; holds the front end
- rob_we / rob_idx  out  1 / RB  ROB write enable, tail slot
- dis_tag  out  RB+1  ROB tag = rob_idx + 1; 0 reserved for "no tag"
- rs_we / rs_idx  out  1 / SB  RS write enable, lowest-index free slot
- lsq_we / lsq_idx  out  1 / LB  LSQ write enable, tail slot
- mt_we  out  1  map-table write for rd
- rob_head  out  RB  commit pointer
- rob_count  out  RB+1  occupied ROB entries
- lsq_count  out  LB+1  occupied LSQ entries
- stall_cycles  out  32  performance counter of dis_stall cycles, saturating

## Operation
- States: RUN, RECOVER. Reset enters RUN. flush from any state enters RECOVER. RECOVER lasts exactly one cycle and then returns to RUN, unless flush is asserted again.
- Resource checks use registered counts only, with no same-cycle bypass of commit or lsq_retire:
  - rob_ok = rob_count < ROB_SIZE
  - rs_ok = bypass_rs | (~&rs_busy)
  - lsq_ok = !needs_lsq | (lsq_count < LSQ_SIZE)
- dis_fire = dis_valid & state==RUN & !flush & rob_ok & rs_ok & lsq_ok.
- rob_we = dis_fire. Every dispatched instruction, including unsupported and ecall, takes a ROB entry.
- rs_we = dis_fire & !bypass_rs.
- lsq_we = dis_fire & needs_lsq.
- mt_we = dis_fire & writes_rd.
- rs_idx is a priority encode of the lowest clear bit of rs_busy. It is 0 when none is free, and rs_we is then 0.
- Pointers wrap modulo size through natural RB/LB-bit overflow.
- rob_tail advances on rob_we. rob_head advances on commit when rob_count != 0.
- rob_count next = count + rob_we − (commit & count!=0).
- LSQ pointers and count follow the same rules using lsq_we and lsq_retire.
- commit or lsq_retire while the queue is empty is ignored.
- On flush, the following are cleared to 0 at the next edge: all pointers, rob_count and lsq_count. Commit and retire asserted in the same cycle are ignored. stall_cycles is not cleared.
- stall_cycles increments on dis_stall and saturates at 0xFFFFFFFF.

## Timing
- All enables, indices and dis_tag are combinational from the current inputs and registered state. The arrays capture the entry at the same clk edge (0-cycle dispatch latency).
- Pointer and count updates become visible the cycle after the event.
- Full ROB with commit in the same cycle: dispatch stalls that cycle and fires the next cycle.
- Reset values: state RUN; every pointer and count 0; stall_cycles 0.
  - Outputs after reset: dis_fire 0, rob_we/rs_we/lsq_we/mt_we 0, rob_head 0, dis_tag 1 (driven, but rob_we is 0 unless dis_fire).
- Reset asserted mid-stream takes priority over flush, commit and dispatch.
- RECOVER cycle: dis_fire=0; dis_stall follows dis_valid.

## Structure
- Shared package holds:
  - the tag-width helper
  - the constant NO_TAG = 0
  - the dispatch_state_t enum {RUN, RECOVER}
- One sub-module, free_slot_picker (parameter N). It takes a busy vector and returns any_free and a lowest-index free idx; it is reused later for the LSQ/FU issue select.
- The ROB and LSQ pointer logic is instantiated twice from a common circ_ptr pattern written inline. It does not need its own module.

## Test plan
- Reset, then 16 back-to-back dis_valid with bypass_rs=1 and no commit → dis_tag 1..16, rob_idx 0..15. The 17th stalls with rob_count=16 and stall_cycles=1.
- Full ROB, then commit plus dis_valid in the same cycle → no fire. Next cycle fire with rob_idx=0, dis_tag=1, rob_head=1.
- rs_busy=8'b1111_0111 with dis_valid and bypass_rs=0 → rs_we=1, rs_idx=3. rs_busy=8'hFF → stall, except when bypass_rs=1, which fires with rs_we=0.
- 8 loads fill the LSQ, then a store → stall. An ALU op with needs_lsq=0 then fires. lsq_retire frees one slot and the store fires with lsq_idx=0.
- flush at rob_count=5 with dis_valid and commit high → no fire. Next cycle RECOVER with pointers and counts 0. The cycle after that, fire with dis_tag=1.
- Reset asserted together with flush and dis_valid → all counts 0, state RUN, dis_fire 0, stall_cycles 0.
